// File: rtl/dsp48a1_pkg.sv
// Shared constants and types for the DSP48A1 operation sequencer.
// OPMODE field encodings follow the DSP48A1 slice: X in [1:0], Z in [3:2].
package dsp48a1_pkg;

  localparam int unsigned AW = 18;
  localparam int unsigned CW = 48;

  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;

  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;

  localparam int unsigned PREADD_EN   = 4;
  localparam int unsigned CARRY       = 5;
  localparam int unsigned PREADD_SUB  = 6;
  localparam int unsigned POSTADD_SUB = 7;

  // P = P + 0 + 0: keeps the accumulator stable while no op is issued.
  localparam logic [7:0] OPMODE_HOLD = {4'b0000, Z_P, X_ZERO};

  typedef enum logic {
    ST_RST_HOLD,
    ST_RUN
  } seq_state_e;

endpackage

// File: rtl/dsp48a1_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO holding {P, CARRYOUT} results.
// Output data reads as zero while empty.
module dsp48a1_rsp_fifo #(
  parameter int unsigned WIDTH = 49,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full    = (count_q == NW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_d    = do_push ? next_ptr(wr_q) : wr_q;
    rd_d    = do_pop  ? next_ptr(rd_q) : rd_q;
    count_d = count_q + NW'(do_push) - NW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/dsp48a1_op_sequencer.sv
// Issues operations to one DSP48A1 slice, tracks them through its fixed
// pipeline with a token shift register and buffers results in order.
module dsp48a1_op_sequencer
  import dsp48a1_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned RST_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [17:0]   req_a,
  input  logic [17:0]   req_b,
  input  logic [17:0]   req_d,
  input  logic [47:0]   req_c,
  input  logic [7:0]    req_opmode,
  input  logic          req_carryin,
  output logic [17:0]   dsp_a,
  output logic [17:0]   dsp_b,
  output logic [17:0]   dsp_d,
  output logic [47:0]   dsp_c,
  output logic [7:0]    dsp_opmode,
  output logic          dsp_carryin,
  output logic          dsp_ce,
  output logic          dsp_rst,
  input  logic [47:0]   dsp_p,
  input  logic          dsp_carryout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [47:0]   rsp_p,
  output logic          rsp_carryout
);

  localparam int unsigned CNTW  = $clog2(DEPTH+1);
  localparam int unsigned HOLDW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  seq_state_e       state_q, state_d;
  logic [HOLDW-1:0] hold_q, hold_d;
  logic             run;

  logic [LATENCY:0] tok_q, tok_d;
  logic [CNTW-1:0]  inflight_q, inflight_d, fifo_count;
  logic [CNTW:0]    credits_used;
  logic             accept, fifo_push, fifo_pop, fifo_empty;
  logic [48:0]      fifo_rdata;

  logic [AW-1:0]    a_q, a_d, b_q, b_d, d_q, d_d;
  logic [CW-1:0]    c_q, c_d;
  logic [7:0]       opmode_q, opmode_d;
  logic             carryin_q, carryin_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    run     = 1'b0;
    dsp_rst = 1'b1;
    dsp_ce  = 1'b0;
    case (state_q)
      ST_RST_HOLD: begin
        if (hold_q == HOLDW'(RST_CYCLES-1)) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HOLDW'(1);
        end
      end
      ST_RUN: begin
        run     = 1'b1;
        dsp_rst = 1'b0;
        dsp_ce  = 1'b1;
      end
      default: state_d = ST_RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST_HOLD;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Credits cover both buffered results and ops still inside the slice.
  assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign req_ready    = run && (credits_used < (CNTW+1)'(DEPTH));
  assign accept       = req_valid && req_ready;
  assign fifo_push    = tok_q[LATENCY];

  always_comb begin
    tok_d      = {tok_q[LATENCY-1:0], accept};
    inflight_d = inflight_q + CNTW'(accept) - CNTW'(fifo_push);
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    d_d       = d_q;
    c_d       = c_q;
    opmode_d  = OPMODE_HOLD;
    carryin_d = 1'b0;
    if (accept) begin
      a_d       = req_a;
      b_d       = req_b;
      d_d       = req_d;
      c_d       = req_c;
      opmode_d  = req_opmode;
      carryin_d = req_carryin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_q      <= '0;
      inflight_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      d_q        <= '0;
      c_q        <= '0;
      opmode_q   <= OPMODE_HOLD;
      carryin_q  <= 1'b0;
    end else begin
      tok_q      <= tok_d;
      inflight_q <= inflight_d;
      a_q        <= a_d;
      b_q        <= b_d;
      d_q        <= d_d;
      c_q        <= c_d;
      opmode_q   <= opmode_d;
      carryin_q  <= carryin_d;
    end
  end

  assign dsp_a       = a_q;
  assign dsp_b       = b_q;
  assign dsp_d       = d_q;
  assign dsp_c       = c_q;
  assign dsp_opmode  = opmode_q;
  assign dsp_carryin = carryin_q;

  assign fifo_pop = rsp_valid && rsp_ready;

  dsp48a1_rsp_fifo #(
    .WIDTH (49),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i ({dsp_p, dsp_carryout}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign rsp_valid    = !fifo_empty;
  assign rsp_p        = fifo_rdata[48:1];
  assign rsp_carryout = fifo_rdata[0];

endmodule
